// File: rtl/serv_dbg_pkg.sv
// Shared definitions for the debug-module register-file access path:
// well-known RF indices and the arbiter state encoding.
package serv_dbg_pkg;

   localparam logic [5:0] MSCRATCH = 6'b010000;
   localparam logic [5:0] MEPC     = 6'b010001;
   localparam logic [5:0] MTVAL    = 6'b010010;
   localparam logic [5:0] DPC      = 6'b010101;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_RDLAT,
      ST_ACK
   } dbg_state_e;

endpackage

// File: rtl/serv_rf_dbg_shift.sv
// 32-bit shift register with parallel load; shifts right by WIDTH bits,
// taking serial data in at the MSB end and presenting the LSB beat.
module serv_rf_dbg_shift #(
   parameter int WIDTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             load_i,
   input  logic [31:0]      load_data_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] ser_i,
   output logic [WIDTH-1:0] ser_o,
   output logic [31:0]      par_o
);

   logic [31:0] sr_q;
   logic [31:0] shifted;

   generate
      if (WIDTH == 32) begin : g_full
         assign shifted = ser_i;
      end else begin : g_part
         assign shifted = {ser_i, sr_q[31:WIDTH]};
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)        sr_q <= '0;
      else if (load_i)  sr_q <= load_data_i;
      else if (shift_i) sr_q <= shifted;
   end

   assign ser_o = sr_q[WIDTH-1:0];
   assign par_o = sr_q;

endmodule

// File: rtl/serv_rf_dbg_arb.sv
// Shares the RF RAM between the core's serial RF port and a debug abstract
// register port; the core wins every beat, debug beats fill the gaps.
module serv_rf_dbg_arb
   import serv_dbg_pkg::*;
#(
   parameter  int WIDTH = 2,
   localparam int N     = 32 / WIDTH,
   localparam int RAW   = $clog2(64 * N)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_halted,
   input  logic [RAW-1:0]   i_core_waddr,
   input  logic [WIDTH-1:0] i_core_wdata,
   input  logic             i_core_wen,
   input  logic [RAW-1:0]   i_core_raddr,
   input  logic             i_core_ren,
   output logic [WIDTH-1:0] o_core_rdata,
   input  logic             i_dbg_req,
   input  logic             i_dbg_we,
   input  logic [5:0]       i_dbg_reg,
   input  logic [31:0]      i_dbg_wdata,
   output logic             o_dbg_ack,
   output logic [31:0]      o_dbg_rdata,
   output logic             o_dbg_busy,
   output logic [RAW-1:0]   o_waddr,
   output logic [WIDTH-1:0] o_wdata,
   output logic             o_wen,
   output logic [RAW-1:0]   o_raddr,
   output logic             o_ren,
   input  logic [WIDTH-1:0] i_rdata
);

   localparam int BW  = (N > 1) ? $clog2(N) : 1;
   localparam int BSH = $clog2(N);

   dbg_state_e     state_q, state_d;
   logic [BW-1:0]  beat_q, beat_d;
   logic [5:0]     reg_q;
   logic           issue_q;

   logic           accept, wr_issue, rd_issue, last_beat;
   logic [RAW-1:0] dbg_addr;
   logic [WIDTH-1:0] sr_ser_o, sr_ser_i;

   assign accept    = (state_q == ST_IDLE) & i_dbg_req & i_halted;
   assign wr_issue  = (state_q == ST_WRITE) & ~i_core_wen;
   assign rd_issue  = (state_q == ST_READ) & ~i_core_ren;
   assign last_beat = (beat_q == BW'(N - 1));
   assign dbg_addr  = (RAW'(reg_q) << BSH) | RAW'(beat_q);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               beat_d  = '0;
               state_d = i_dbg_we ? ST_WRITE : ST_READ;
            end
         end
         ST_WRITE: begin
            if (wr_issue) begin
               beat_d = last_beat ? '0 : beat_q + BW'(1);
               if (last_beat) state_d = ST_ACK;
            end
         end
         ST_READ: begin
            if (rd_issue) begin
               beat_d = last_beat ? '0 : beat_q + BW'(1);
               if (last_beat) state_d = ST_RDLAT;
            end
         end
         ST_RDLAT: state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         reg_q   <= '0;
         issue_q <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         issue_q <= rd_issue;
         if (accept) reg_q <= i_dbg_reg;
      end
   end

   // x0 reads shift in zeros so the result is 0 whatever the RAM holds.
   assign sr_ser_i = (issue_q && reg_q != 6'd0) ? i_rdata : '0;

   serv_rf_dbg_shift #(.WIDTH(WIDTH)) u_shift (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .load_i      (accept),
      .load_data_i (i_dbg_we ? i_dbg_wdata : 32'd0),
      .shift_i     (wr_issue | issue_q),
      .ser_i       (sr_ser_i),
      .ser_o       (sr_ser_o),
      .par_o       (o_dbg_rdata)
   );

   assign o_waddr = wr_issue ? dbg_addr : i_core_waddr;
   assign o_wdata = wr_issue ? sr_ser_o : i_core_wdata;
   assign o_wen   = i_core_wen | (wr_issue & (reg_q != 6'd0));
   assign o_raddr = rd_issue ? dbg_addr : i_core_raddr;
   assign o_ren   = i_core_ren | rd_issue;

   assign o_core_rdata = i_rdata;
   assign o_dbg_ack    = (state_q == ST_ACK);
   assign o_dbg_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Randomised bench for serv_rf_dbg_arb: a behavioural RAM plus a 64x32
// register model predicts debug results, beat addresses and ack latency.
module tb_serv_rf_dbg_arb;
   import serv_dbg_pkg::*;

   localparam int WIDTH = 2;
   localparam int N     = 32 / WIDTH;
   localparam int RAW   = $clog2(64 * N);
   localparam int BSH   = $clog2(N);

   logic             i_clk, i_rst, i_halted;
   logic [RAW-1:0]   i_core_waddr, i_core_raddr;
   logic [WIDTH-1:0] i_core_wdata, o_core_rdata;
   logic             i_core_wen, i_core_ren;
   logic             i_dbg_req, i_dbg_we;
   logic [5:0]       i_dbg_reg;
   logic [31:0]      i_dbg_wdata, o_dbg_rdata;
   logic             o_dbg_ack, o_dbg_busy;
   logic [RAW-1:0]   o_waddr, o_raddr;
   logic [WIDTH-1:0] o_wdata, i_rdata;
   logic             o_wen, o_ren;

   serv_rf_dbg_arb #(.WIDTH(WIDTH)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_halted(i_halted),
      .i_core_waddr(i_core_waddr), .i_core_wdata(i_core_wdata), .i_core_wen(i_core_wen),
      .i_core_raddr(i_core_raddr), .i_core_ren(i_core_ren), .o_core_rdata(o_core_rdata),
      .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we), .i_dbg_reg(i_dbg_reg),
      .i_dbg_wdata(i_dbg_wdata), .o_dbg_ack(o_dbg_ack), .o_dbg_rdata(o_dbg_rdata),
      .o_dbg_busy(o_dbg_busy), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_wen(o_wen),
      .o_raddr(o_raddr), .o_ren(o_ren), .i_rdata(i_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   logic [WIDTH-1:0] mem [64*N];
   logic [31:0]      refm [64];

   always @(posedge i_clk) begin
      if (o_wen) mem[o_waddr] <= o_wdata;
      if (o_ren) i_rdata <= mem[o_raddr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RAW-1:0] addr(input logic [5:0] r, input int b);
      return RAW'((int'(r) << BSH) + b);
   endfunction

   // Core traffic stays in regs 48..63 so it never overlaps debug targets.
   task automatic drive_core(input bit wen, input bit ren);
      logic [5:0] r;
      int b;
      r = 6'($urandom_range(48, 63));
      b = $urandom_range(0, N - 1);
      i_core_wen   = wen;
      i_core_ren   = ren;
      i_core_waddr = addr(r, b);
      i_core_wdata = WIDTH'($urandom);
      if (wen) refm[r][b*WIDTH +: WIDTH] = i_core_wdata;
      i_core_raddr = addr(6'($urandom_range(48, 63)), $urandom_range(0, N - 1));
   endtask

   task automatic chk_core();
      if (i_core_wen) chk("core_w", {o_wen, o_waddr, o_wdata}, {1'b1, i_core_waddr, i_core_wdata});
      if (i_core_ren) chk("core_r", {o_ren, o_raddr}, {1'b1, i_core_raddr});
      chk("core_rdata", o_core_rdata, i_rdata);
   endtask

   task automatic do_txn(input bit we, input logic [5:0] r, input logic [31:0] wd,
                         input logic [127:0] stall, input int rst_at);
      int nb, ackc, remaining, last, exp_ack;
      bit s;
      logic [31:0] exp_rd;
      remaining = N;
      last = 0;
      for (int c = 1; c < 128; c++) begin
         if (!stall[c]) begin
            remaining--;
            if (remaining == 0) begin last = c; break; end
         end
      end
      exp_ack = last + (we ? 1 : 2);
      exp_rd  = (r == 6'd0) ? 32'd0 : refm[r];

      @(posedge i_clk); #1;
      i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_reg = r; i_dbg_wdata = wd; i_halted = 1'b1;
      drive_core(1'b0, 1'b0);
      @(negedge i_clk);
      chk("idle_busy", o_dbg_busy, 0);

      nb = 0;
      ackc = 0;
      for (int c = 1; c <= 200 && ackc == 0; c++) begin
         @(posedge i_clk); #1;
         s = (c < 128) ? stall[c] : 1'b0;
         i_dbg_req = 1'b0; i_dbg_we = 1'($urandom); i_dbg_reg = 6'($urandom);
         i_dbg_wdata = $urandom;
         i_halted = 1'($urandom);
         if (we) drive_core(s, 1'($urandom));
         else    drive_core($urandom_range(0, 3) == 0, s);
         if (c == rst_at) i_rst = 1'b1;
         @(negedge i_clk);
         chk_core();
         if (c == rst_at) begin
            chk("rst_busy", o_dbg_busy, 0);
            chk("rst_ack", o_dbg_ack, 0);
            chk("rst_rdata", o_dbg_rdata, 0);
            @(posedge i_clk); #1;
            i_rst = 1'b0;
            drive_core(1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
               @(negedge i_clk);
               chk("rst_noack", {o_dbg_ack, o_dbg_busy}, 0);
               @(posedge i_clk); #1;
            end
            return;
         end
         if (we && !i_core_wen && o_wen) begin
            chk("dw_addr", o_waddr, addr(r, nb));
            chk("dw_data", o_wdata, wd[nb*WIDTH +: WIDTH]);
            nb++;
         end
         if (!we && !i_core_ren && o_ren) begin
            chk("dr_addr", o_raddr, addr(r, nb));
            nb++;
         end
         if (o_dbg_ack) ackc = c;
         else chk("busy", o_dbg_busy, 1);
      end
      chk("ack_cyc", ackc, exp_ack);
      chk("beats", nb, (we && r == 6'd0) ? 0 : N);
      if (!we) chk("rdata", o_dbg_rdata, exp_rd);
      else if (r != 6'd0) refm[r] = wd;

      @(posedge i_clk); #1;
      drive_core(1'b0, 1'b0);
      i_halted = 1'b1;
      @(negedge i_clk);
      chk("post_idle", {o_dbg_ack, o_dbg_busy}, 0);
      if (!we) chk("rdata_hold", o_dbg_rdata, exp_rd);
   endtask

   initial begin
      logic [127:0] st;
      int acks[$];
      i_rst = 1'b1; i_halted = 1'b0; i_dbg_req = 1'b0; i_dbg_we = 1'b0;
      i_dbg_reg = '0; i_dbg_wdata = '0;
      i_core_wen = 1'b0; i_core_ren = 1'b0; i_core_waddr = '0; i_core_raddr = '0;
      i_core_wdata = '0;
      for (int r = 0; r < 64; r++) refm[r] = $urandom;
      refm[0] = 32'h1234_5678;
      for (int r = 0; r < 64; r++)
         for (int b = 0; b < N; b++) mem[r*N + b] <= refm[r][b*WIDTH +: WIDTH];

      #2;
      chk("rst_state", {o_dbg_ack, o_dbg_busy, o_dbg_rdata}, 0);
      chk("rst_pass", {o_wen, o_ren}, 0);
      @(posedge i_clk); #1;
      i_rst = 1'b0;

      // directed: write/read reg 5, x0 write/read, DPC read with core stalls
      do_txn(1'b1, 6'd5, 32'hDEADBEEF, '0, 0);
      do_txn(1'b0, 6'd5, 32'h0, '0, 0);
      chk("reg5", o_dbg_rdata, 32'hDEADBEEF);
      do_txn(1'b1, 6'd0, 32'hFFFFFFFF, '0, 0);
      do_txn(1'b0, 6'd0, 32'h0, '0, 0);
      st = '0; st[5] = 1'b1; st[6] = 1'b1; st[7] = 1'b1;
      do_txn(1'b0, DPC, 32'h0, st, 0);

      // request while running: held off until halted
      @(posedge i_clk); #1;
      i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = MEPC; i_halted = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         chk("not_halted_busy", o_dbg_busy, 0);
         @(posedge i_clk); #1;
      end
      do_txn(1'b1, MEPC, 32'hCAFE_F00D, '0, 0);
      do_txn(1'b0, MEPC, 32'h0, '0, 0);

      // reset mid-write, then a full restart of the same register
      do_txn(1'b1, MTVAL, 32'hA5A5_5A5A, '0, 8);
      do_txn(1'b1, MTVAL, 32'h0F1E_2D3C, '0, 0);
      do_txn(1'b0, MTVAL, 32'h0, '0, 0);

      // req held high across ack: two reads, one idle cycle between
      @(posedge i_clk); #1;
      i_dbg_req = 1'b1; i_dbg_we = 1'b0; i_dbg_reg = 6'd7; i_halted = 1'b1;
      drive_core(1'b0, 1'b0);
      for (int c = 1; c <= 2*N + 6; c++) begin
         @(posedge i_clk); #1;
         if (c >= 2*N + 5) i_dbg_req = 1'b0;
         @(negedge i_clk);
         if (o_dbg_ack) acks.push_back(c);
         if (c == N + 3) chk("b2b_idle", o_dbg_busy, 0);
         if (c == 2*N + 6) chk("b2b_end", o_dbg_busy, 0);
      end
      chk("b2b_nacks", acks.size(), 2);
      if (acks.size() == 2) begin
         chk("b2b_ack0", acks[0], N + 2);
         chk("b2b_ack1", acks[1], 2*N + 5);
      end
      chk("b2b_rdata", o_dbg_rdata, refm[7]);

      // random traffic
      for (int t = 0; t < 40; t++) begin
         for (int c = 0; c < 128; c++) st[c] = ($urandom_range(0, 3) == 0);
         do_txn(1'($urandom), 6'($urandom_range(0, 47)), $urandom, st, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
